mag_comp_seq: RTL and testbench
===============================

Name: mag_comp_seq

Overview:
Parametrised, multi-cycle magnitude comparator and successor to the combinational 4-bit comparators.
- Compares two WIDTH-bit operands CHUNK bits per cycle, MSB-first.
- Supports an unsigned or two's-complement signed mode.
- Terminates early at the first differing chunk and reports eq/gr/lt through a start/busy/done handshake.
- Used where wide compares must not sit in a single-cycle combinational path.

Parameters:
WIDTH, 16, operand width in bits; must be >= 2.
CHUNK, 4, bits compared per cycle; WIDTH % CHUNK must be 0. NCHUNK = WIDTH/CHUNK.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request a compare; accepted only when busy=0
signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled with start
a  input  WIDTH  operand A; sampled with start
b  input  WIDTH  operand B; sampled with start
busy  output  1  compare in progress
done  output  1  one-cycle pulse; result valid and updated
eq  output  1  a == b (registered, held)
gr  output  1  a > b (registered, held)
lt  output  1  a < b (registered, held)

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; busy, done, eq, gr, lt = 0; chunk index = 0. Reset mid-compare aborts the compare; no done is issued.
- States:
  - IDLE: start=1 at a rising edge captures a, b and signed_mode, sets chunk index=0, busy=1, and moves to CMP.
  - CMP: each cycle compares chunk i = bits [WIDTH-1-i*CHUNK -: CHUNK] of the captured operands.
    - Chunks differ: register gr/lt from that chunk's unsigned compare, eq=0, done=1, busy=0, return to IDLE.
    - Chunks equal and i = NCHUNK-1: eq=1, gr=0, lt=0, done=1, busy=0, return to IDLE.
    - Chunks equal and i < NCHUNK-1: increment i, stay in CMP.
- Signed mode: invert the MSB of both captured operands at capture (offset-binary). An unsigned compare of the inverted operands gives the signed result. Sign mismatch therefore always resolves in chunk 0.
- Latency: with start sampled at edge t and first differing chunk k (0-based), done is high in the cycle after edge t+k+1. An equal result takes NCHUNK cycles. Minimum latency is 1 cycle, maximum is NCHUNK.
- done is high for exactly one cycle per accepted start.
- eq/gr/lt are exactly one-hot after the first completion. They hold their value until the next completion and do not change during busy.
- start while busy=1 is ignored; no queueing.
- start in the same cycle as done=1 is accepted, because busy is already 0. Back-to-back compares have no idle gap.
- Changes on a/b/signed_mode after capture have no effect on the compare in flight.

Optional Feature:
MAG_COMP_CONST_TIME_EN
- Defined: early termination is disabled. The first difference is latched internally, all NCHUNK chunks are always scanned, and done always occurs NCHUNK cycles after start. eq/gr/lt values are identical to the non-macro build. This gives data-independent timing.
- Undefined: early termination as described in Behaviour.

Test Plan:
1. WIDTH=16, CHUNK=4, unsigned, a=16'h8000, b=16'h0001 -> gr=1, eq=0, lt=0; done 1 cycle after start (NCHUNK=4 cycles with MAG_COMP_CONST_TIME_EN).
2. Same operands, signed_mode=1 -> lt=1; done 1 cycle after start.
3. a=b=16'hA5A5, either mode -> eq=1; done exactly 4 cycles after start; busy high for 4 cycles.
4. a=16'h1234, b=16'h1235, unsigned -> lt=1 after 4 cycles. Then, in the done cycle, start with a=16'hFFFF, b=16'h0000 signed -> lt=1 after 1 cycle (0 idle gap). Finally, a start pulse while busy is ignored: exactly one done, result unchanged.
5. Reset mid-op: start with a=16'h0F00, b=16'h0F01, assert rst_n=0 during cycle 2 -> busy/done/eq/gr/lt=0 immediately. After release, no done appears until a new start.
6. Randomised sweep, WIDTH=12, CHUNK=3, both modes, 1000 vectors -> eq/gr/lt match a reference ==, >, < (signed cast when signed_mode=1). Latency equals first differing chunk + 1 (always 4 with MAG_COMP_CONST_TIME_EN).

Source files
------------

// File: rtl/mag_comp_seq_if.sv
// Handshake/operand bundle for mag_comp_seq.
// The master side drives start and the operands; the slave side returns busy/done and the result.
interface mag_comp_seq_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             eq;
    logic             gr;
    logic             lt;

    modport master (output start, signed_mode, a, b, input  busy, done, eq, gr, lt);
    modport slave  (input  start, signed_mode, a, b, output busy, done, eq, gr, lt);
endinterface

// File: rtl/mag_comp_seq.sv
// Multi-cycle MSB-first magnitude comparator, CHUNK bits per cycle, unsigned or signed.
// Define MAG_COMP_CONST_TIME_EN to always scan every chunk (data-independent latency).
module mag_comp_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    mag_comp_seq_if.slave  bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);
    localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic {IDLE, CMP} state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic             busy_q, done_q, eq_q, gr_q, lt_q;
    logic             busy_nxt, done_nxt, eq_nxt, gr_nxt, lt_nxt;
    logic [CHUNK-1:0] ca, cb;
    logic             last, accept;

    // Operands are shifted left each cycle so the active chunk always sits at the top.
    assign ca     = a_sh[WIDTH-1 -: CHUNK];
    assign cb     = b_sh[WIDTH-1 -: CHUNK];
    assign last   = (idx == LAST_IDX);
    assign accept = (state == IDLE) && bus.start;

`ifdef MAG_COMP_CONST_TIME_EN
    logic seen, seen_gr, seen_nxt, seen_gr_nxt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            idx    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            eq_q   <= 1'b0;
            gr_q   <= 1'b0;
            lt_q   <= 1'b0;
`ifdef MAG_COMP_CONST_TIME_EN
            seen    <= 1'b0;
            seen_gr <= 1'b0;
`endif
        end else begin
            state  <= state_nxt;
            idx    <= idx_nxt;
            busy_q <= busy_nxt;
            done_q <= done_nxt;
            eq_q   <= eq_nxt;
            gr_q   <= gr_nxt;
            lt_q   <= lt_nxt;
`ifdef MAG_COMP_CONST_TIME_EN
            seen    <= seen_nxt;
            seen_gr <= seen_gr_nxt;
`endif
        end
    end

    // Flipping both MSBs maps two's complement onto offset binary, so one unsigned path serves both modes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh <= '0;
            b_sh <= '0;
        end else if (accept) begin
            a_sh <= bus.a ^ (bus.signed_mode ? MSB_MASK : '0);
            b_sh <= bus.b ^ (bus.signed_mode ? MSB_MASK : '0);
        end else if (state == CMP) begin
            a_sh <= a_sh << CHUNK;
            b_sh <= b_sh << CHUNK;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        busy_nxt  = busy_q;
        done_nxt  = 1'b0;
        eq_nxt    = eq_q;
        gr_nxt    = gr_q;
        lt_nxt    = lt_q;
`ifdef MAG_COMP_CONST_TIME_EN
        seen_nxt    = seen;
        seen_gr_nxt = seen_gr;
`endif
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = CMP;
                    idx_nxt   = '0;
                    busy_nxt  = 1'b1;
`ifdef MAG_COMP_CONST_TIME_EN
                    seen_nxt    = 1'b0;
                    seen_gr_nxt = 1'b0;
`endif
                end
            end
            CMP: begin
`ifdef MAG_COMP_CONST_TIME_EN
                // Only the first difference decides; later chunks are scanned purely for timing.
                if (!seen && (ca != cb)) begin
                    seen_nxt    = 1'b1;
                    seen_gr_nxt = (ca > cb);
                end
                if (last) begin
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    if (seen) begin
                        eq_nxt = 1'b0;
                        gr_nxt = seen_gr;
                        lt_nxt = !seen_gr;
                    end else begin
                        eq_nxt = (ca == cb);
                        gr_nxt = (ca > cb);
                        lt_nxt = (ca < cb);
                    end
                end else begin
                    idx_nxt = idx + 1'b1;
                end
`else
                if (ca != cb) begin
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    eq_nxt    = 1'b0;
                    gr_nxt    = (ca > cb);
                    lt_nxt    = (ca < cb);
                end else if (last) begin
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    eq_nxt    = 1'b1;
                    gr_nxt    = 1'b0;
                    lt_nxt    = 1'b0;
                end else begin
                    idx_nxt = idx + 1'b1;
                end
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.eq   = eq_q;
    assign bus.gr   = gr_q;
    assign bus.lt   = lt_q;
endmodule

// File: tb/tb_mag_comp_seq.sv
// Bench for mag_comp_seq: directed cases on a 16/4 instance, randomized sweep on a 12/3 instance.
module tb_mag_comp_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mag_comp_seq_if #(.WIDTH(16)) b16 ();
    mag_comp_seq_if #(.WIDTH(12)) b12 ();

    mag_comp_seq #(.WIDTH(16), .CHUNK(4)) u16 (.clk(clk), .rst_n(rst_n), .bus(b16));
    mag_comp_seq #(.WIDTH(12), .CHUNK(3)) u12 (.clk(clk), .rst_n(rst_n), .bus(b12));

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected {eq,gr,lt} from plain integer compare, sign-extending by hand in signed mode.
    function automatic logic [2:0] ref_res(input logic [31:0] a, input logic [31:0] b,
                                           input int w, input logic sm);
        longint sa, sb;
        sa = longint'(a);
        sb = longint'(b);
        if (sm) begin
            if (a[w-1]) sa = sa - (longint'(1) << w);
            if (b[w-1]) sb = sb - (longint'(1) << w);
        end
        return {sa == sb, sa > sb, sa < sb};
    endfunction

    // Expected latency: index of the first chunk where the operands differ, plus one.
    function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b, input int w, input int c);
`ifdef MAG_COMP_CONST_TIME_EN
        return w / c;
`else
        for (int k = 0; k < w / c; k++)
            if (((a ^ b) >> (w - (k + 1) * c)) != 0) return k + 1;
        return w / c;
`endif
    endfunction

    task automatic go16(input logic [15:0] a, input logic [15:0] b, input logic sm, input string tag);
        int lat, bcnt;
        b16.a = a; b16.b = b; b16.signed_mode = sm; b16.start = 1'b1;
        @(negedge clk);
        b16.start = 1'b0;
        b16.a = 16'($urandom); b16.b = 16'($urandom); b16.signed_mode = 1'($urandom);
        lat = 0; bcnt = 0;
        while (!b16.done && lat < 64) begin
            if (b16.busy) bcnt++;
            @(negedge clk);
            lat++;
        end
        chk({tag, ".lat"}, lat, ref_lat({16'h0, a}, {16'h0, b}, 16, 4));
        chk({tag, ".res"}, 32'({b16.eq, b16.gr, b16.lt}), 32'(ref_res({16'h0, a}, {16'h0, b}, 16, sm)));
        chk({tag, ".busycyc"}, bcnt, lat);
        chk({tag, ".busy_at_done"}, 32'(b16.busy), 0);
    endtask

    task automatic go12(input logic [11:0] a, input logic [11:0] b, input logic sm, input string tag);
        int lat;
        b12.a = a; b12.b = b; b12.signed_mode = sm; b12.start = 1'b1;
        @(negedge clk);
        b12.start = 1'b0;
        b12.a = 12'($urandom); b12.b = 12'($urandom);
        lat = 0;
        while (!b12.done && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, ".lat"}, lat, ref_lat({20'h0, a}, {20'h0, b}, 12, 3));
        chk({tag, ".res"}, 32'({b12.eq, b12.gr, b12.lt}), 32'(ref_res({20'h0, a}, {20'h0, b}, 12, sm)));
    endtask

    initial begin
        int dn;
        logic [11:0] ra, rb;
        b16.start = 1'b0; b16.signed_mode = 1'b0; b16.a = '0; b16.b = '0;
        b12.start = 1'b0; b12.signed_mode = 1'b0; b12.a = '0; b12.b = '0;

        repeat (3) @(negedge clk);
        chk("rst.busy", 32'(b16.busy), 0);
        chk("rst.done", 32'(b16.done), 0);
        chk("rst.res", 32'({b16.eq, b16.gr, b16.lt}), 0);
        rst_n = 1'b1;
        @(negedge clk);

        go16(16'h8000, 16'h0001, 1'b0, "t1_unsigned");
        go16(16'h8000, 16'h0001, 1'b1, "t2_signed");
        go16(16'hA5A5, 16'hA5A5, 1'b0, "t3_eq_u");
        go16(16'hA5A5, 16'hA5A5, 1'b1, "t3_eq_s");

        // Back-to-back: second start issued in the done cycle of the first.
        go16(16'h1234, 16'h1235, 1'b0, "t4_lt");
        go16(16'hFFFF, 16'h0000, 1'b1, "t4_b2b");

        // Start while busy must be dropped.
        b16.a = 16'h1234; b16.b = 16'h1235; b16.signed_mode = 1'b0; b16.start = 1'b1;
        @(negedge clk);
        b16.start = 1'b0;
        @(negedge clk);
        b16.a = 16'hFFFF; b16.b = 16'h0000; b16.start = 1'b1;
        @(negedge clk);
        b16.start = 1'b0;
        dn = 0;
        repeat (10) begin
            if (b16.done) dn++;
            @(negedge clk);
        end
        chk("t4_ignore.dones", dn, 1);
        chk("t4_ignore.res", 32'({b16.eq, b16.gr, b16.lt}), 32'h1);

        // Reset mid-compare.
        b16.a = 16'h0F00; b16.b = 16'h0F01; b16.signed_mode = 1'b0; b16.start = 1'b1;
        @(negedge clk);
        b16.start = 1'b0;
        @(negedge clk);
        chk("t5.busy_before", 32'(b16.busy), 1);
        rst_n = 1'b0;
        #1;
        chk("t5.busy", 32'(b16.busy), 0);
        chk("t5.done", 32'(b16.done), 0);
        chk("t5.res", 32'({b16.eq, b16.gr, b16.lt}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        repeat (8) begin
            @(negedge clk);
            if (b16.done || b16.busy) dn++;
        end
        chk("t5.no_done", dn, 0);

        // Randomized sweep; bias some vectors toward equal or single-bit differences.
        for (int i = 0; i < 1000; i++) begin
            ra = 12'($urandom);
            rb = 12'($urandom);
            case (i % 4)
                1: rb = ra;
                2: rb = ra ^ (12'h1 << $urandom_range(0, 11));
                default: ;
            endcase
            go12(ra, rb, 1'($urandom), $sformatf("t6[%0d]", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
